pool2d_stream: RTL
==================

Name: pool2d_stream

Overview:
- Parametrised 2x2 / stride-2 pooling stage for the CNN feature-map path. Successor to the fixed 22-bit max-pool stage.
- Takes one raster-order feature map per frame and emits (IMG_W/2)x(IMG_H/2) pooled values.
- Pooling mode is selectable per frame: max or rounded average.
- Adds valid/ready backpressure on both sides, odd-dimension handling, out_last, busy, and a half-width row buffer that stores horizontal partial results.

Parameters:
- DATA_W, 22, signed sample width for both input and output.
- IMG_W, 32, input frame width in pixels. Must be ≥2; may be odd.
- IMG_H, 32, input frame height in rows. Must be ≥2; may be odd.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  frame start request. Honoured only in IDLE.
- mode  in  1  0 = max, 1 = average. Sampled when start is accepted.
- in_valid  in  1  input sample valid.
- in_ready  out  1  block can accept a sample.
- in_data  in  DATA_W  signed input sample.
- out_valid  out  1  pooled result valid.
- out_ready  in  1  downstream accepts the result.
- out_data  out  DATA_W  signed pooled result.
- out_last  out  1  qualifies the final pooled result of the frame.
- busy  out  1  high in RUN and DRAIN.
- done  out  1  one-cycle pulse at frame completion.

Behaviour:
- Reset values: out_valid, out_data, out_last, done, busy, in_ready are all 0. State = IDLE. Counters and row buffer cleared. mode_q = max.
- Reset mid-frame aborts the frame immediately. No done pulse; the partial frame is discarded.
- FSM states are IDLE, RUN, DRAIN, DONE.
  - IDLE -> RUN on start. mode is latched into mode_q; x and y are cleared.
  - RUN -> DRAIN on acceptance of pixel (IMG_H-1, IMG_W-1).
  - DRAIN -> DONE when out_valid is 0, or when an out_valid && out_ready handshake occurs.
  - DONE -> IDLE unconditionally. done=1 only in DONE.
  - start outside IDLE is ignored.
- Input acceptance: accept = in_valid && in_ready, where in_ready = (state==RUN) && (!out_valid || out_ready). in_data is ignored whenever accept is 0.
- Counters advance only on accept. x wraps from IMG_W-1 to 0 and increments y. Widths are $clog2 of the dimension.
- Horizontal pair (x odd): prev is the registered sample from x-1, h = combine(prev, in_data).
  - max mode: h is the signed maximum.
  - avg mode: h is the signed sum, DATA_W+1 bits.
- Even y: h is written to rowbuf[x>>1]. rowbuf has IMG_W/2 entries of DATA_W+1 bits.
- Odd y, x odd: window result w = combine(rowbuf[x>>1], h).
  - Sums are DATA_W+2 bits wide.
  - avg result = (sum + 2) >>> 2, i.e. round half toward +inf, truncated back to DATA_W. Cannot overflow.
- Output register: on the accept that produces w, the next cycle shows out_valid=1 and out_data=w (latency 1).
  - out_last=1 when the window covers row IMG_H-2|IMG_H-1 (even-floor) and the last full column pair.
  - out_valid, out_data and out_last are held stable until out_ready.
  - If a new result is produced in the same cycle as a handshake, it replaces the old one seamlessly, so throughput is 1 sample/cycle.
- Odd IMG_W: column IMG_W-1 is accepted and discarded. Odd IMG_H: row IMG_H-1 is accepted and discarded, and out_last belongs to row IMG_H-2.
- Signed compares throughout. Ties select either value; the results are identical.

Decomposition:
- Package pool_pkg:
  - pool_mode_e {POOL_MAX=0, POOL_AVG=1}.
  - pool_state_e {IDLE, RUN, DRAIN, DONE}.
  - Function pool_combine(mode, a, b) returning a DATA_W+2 max/sum.
  - Function pool_avg_round(sum4).
- Sub-module pool_row_buffer: half-width synchronous-write / async-read storage, parameters DEPTH and W, with wr_en, wr_addr, wr_data, rd_addr, rd_data.

Test Plan:
- Max, IMG 4x4, DATA_W 22, ramp 0..15, out_ready=1 -> outputs 5,7,13,15. out_last with 15. done 1 cycle after DRAIN exits.
- Avg, same ramp -> outputs 3,5,11,13. Window {0,1,4,5}: sum 10 -> 12>>2 = 3.
- Signed, 2x2 frames:
  - Max of {-5,-3,-8,-100} -> -3.
  - Avg of {-1,-2,-2,-2} -> -2.
  - Avg of 4x(2^21-1) -> 2^21-1.
  - Avg of 4x(-2^21) -> -2^21.
- Backpressure, 4x4 max ramp with out_ready held 0 for 6 cycles after the first result -> in_ready drops. Results 5,7,13,15 arrive in order, no loss or duplicates, out_data stable while stalled.
- Odd dims, IMG_W=5, IMG_H=3, ramp 0..14, max -> outputs 6,8 only. out_last with 8. done pulses once.
- Control:
  - start asserted during RUN -> ignored; mode change mid-frame has no effect.
  - rst asserted after 7 pixels -> all outputs 0, state IDLE, no done. A new start then yields a correct full frame.

Source files
------------

// File: rtl/pool_pkg.sv
// pool_pkg: shared types and arithmetic helpers for the 2x2 pooling stage.
// Arithmetic is done in a wide signed accumulator and narrowed by the caller.
package pool_pkg;

    localparam int POOL_MAX_W = 64;

    typedef enum logic {
        POOL_MAX = 1'b0,
        POOL_AVG = 1'b1
    } pool_mode_e;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } pool_state_e;

    typedef logic signed [POOL_MAX_W-1:0] pool_acc_t;

    function automatic pool_acc_t pool_combine(
        pool_mode_e mode,
        pool_acc_t  a,
        pool_acc_t  b
    );
        if (mode == POOL_AVG)
            return a + b;
        return (a > b) ? a : b;
    endfunction

    // Divide a four-sample sum by 4, rounding half toward +inf.
    function automatic pool_acc_t pool_avg_round(pool_acc_t sum4);
        return (sum4 + pool_acc_t'(2)) >>> 2;
    endfunction

endpackage

// File: rtl/pool_row_buffer.sv
// pool_row_buffer: half-width storage for horizontal partial results.
// Synchronous write, asynchronous read; storage rounds up to a power of two.
module pool_row_buffer #(
    parameter int DEPTH = 16,
    parameter int W     = 23,
    parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [W-1:0]  wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [W-1:0]  rd_data
);

    localparam int N = 1 << AW;

    logic [W-1:0] mem [N];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N; i++)
                mem[i] <= '0;
        end else if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/pool2d_stream.sv
// pool2d_stream: 2x2 stride-2 max / rounded-average pooling of a raster frame.
// Valid/ready on both sides; odd trailing row/column are accepted and dropped.
module pool2d_stream
    import pool_pkg::*;
#(
    parameter int DATA_W = 22,
    parameter int IMG_W  = 32,
    parameter int IMG_H  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              mode,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              busy,
    output logic              done
);

    localparam int XW     = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int YW     = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int HALF   = IMG_W / 2;
    localparam int AW     = (HALF > 1) ? $clog2(HALF) : 1;
    localparam int LAST_X = (IMG_W / 2) * 2 - 1;
    localparam int LAST_Y = (IMG_H / 2) * 2 - 1;

    pool_state_e state_q;
    pool_state_e state_d;
    pool_mode_e  mode_q;

    logic [XW-1:0]            x_q;
    logic [YW-1:0]            y_q;
    logic signed [DATA_W-1:0] prev_q;
    logic signed [DATA_W-1:0] in_s;
    logic signed [DATA_W:0]   h;
    logic signed [DATA_W:0]   rb_rd;
    logic signed [DATA_W-1:0] w_res;
    logic [AW-1:0]            pair_addr;

    logic run;
    logic accept;
    logic end_x;
    logic end_frame;
    logic produce;
    logic rb_wr;
    logic is_last;

    assign in_s      = in_data;
    assign accept    = in_valid && in_ready;
    assign end_x     = (x_q == XW'(IMG_W - 1));
    assign end_frame = end_x && (y_q == YW'(IMG_H - 1));
    assign produce   = accept && x_q[0] && y_q[0];
    assign rb_wr     = accept && x_q[0] && !y_q[0];
    assign is_last   = (x_q == XW'(LAST_X)) && (y_q == YW'(LAST_Y));
    assign pair_addr = AW'(x_q >> 1);

    always_ff @(posedge clk) begin
        if (rst)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (accept && end_frame) state_d = DRAIN;
            DRAIN:   if (!out_valid || out_ready) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        run  = 1'b0;
        busy = 1'b0;
        done = 1'b0;
        unique case (state_q)
            RUN: begin
                run  = 1'b1;
                busy = 1'b1;
            end
            DRAIN:   busy = 1'b1;
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    assign in_ready = run && (!out_valid || out_ready);

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q <= POOL_MAX;
            x_q    <= '0;
            y_q    <= '0;
            prev_q <= '0;
        end else if (state_q == IDLE && start) begin
            mode_q <= pool_mode_e'(mode);
            x_q    <= '0;
            y_q    <= '0;
        end else if (accept) begin
            if (!x_q[0])
                prev_q <= in_s;
            if (end_x) begin
                x_q <= '0;
                y_q <= end_frame ? '0 : y_q + 1'b1;
            end else begin
                x_q <= x_q + 1'b1;
            end
        end
    end

    assign h = (DATA_W + 1)'(pool_combine(mode_q,
                                          pool_acc_t'(prev_q),
                                          pool_acc_t'(in_s)));

    pool_row_buffer #(
        .DEPTH (HALF),
        .W     (DATA_W + 1),
        .AW    (AW)
    ) u_rowbuf (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (rb_wr),
        .wr_addr (pair_addr),
        .wr_data (h),
        .rd_addr (pair_addr),
        .rd_data (rb_rd)
    );

    // Max results always fit DATA_W; averaged sums are rounded then narrowed.
    always_comb begin
        if (mode_q == POOL_AVG)
            w_res = DATA_W'(pool_avg_round(
                        pool_combine(POOL_AVG,
                                     pool_acc_t'(rb_rd),
                                     pool_acc_t'(h))));
        else
            w_res = DATA_W'(pool_combine(POOL_MAX,
                                         pool_acc_t'(rb_rd),
                                         pool_acc_t'(h)));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
        end else if (produce) begin
            out_valid <= 1'b1;
            out_data  <= w_res;
            out_last  <= is_last;
        end else if (out_ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end
    end

endmodule
